// File: rtl/maq_pkg.sv
// Shared BCD types and helpers for the
// hour/minute/second counter family.
package maq_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Two BCD digits to a binary value (0..99)
  function automatic logic [6:0] bcd2bin(
    input bcd_t msd,
    input bcd_t lsd
  );
    return 7'(msd) * 7'd10 + 7'(lsd);
  endfunction

endpackage

// File: rtl/maq_disp12.sv
// 24-hour BCD count to 12-hour display
// digits plus PM flag.
module maq_disp12
  import maq_pkg::*;
(
  input  bcd_t msd_i,
  input  bcd_t lsd_i,
  input  logic modo12_i,
  output bcd_t disp_msd_o,
  output bcd_t disp_lsd_o,
  output logic pm_o
);

  logic [6:0] bin;
  logic [6:0] pm_h;

  assign bin  = bcd2bin(msd_i, lsd_i);
  assign pm_h = bin - 7'd12;

  // Midnight and noon show 12; afternoon
  // hours fold down by twelve.
  always_comb begin
    disp_msd_o = msd_i;
    disp_lsd_o = lsd_i;
    pm_o       = 1'b0;
    if (modo12_i) begin
      unique case (1'b1)
        (bin == 7'd0): begin
          disp_msd_o = 4'd1;
          disp_lsd_o = 4'd2;
        end
        (bin == 7'd12): begin
          disp_msd_o = 4'd1;
          disp_lsd_o = 4'd2;
          pm_o       = 1'b1;
        end
        (bin > 7'd12 && pm_h >= 7'd10): begin
          disp_msd_o = 4'd1;
          disp_lsd_o = 4'(pm_h - 7'd10);
          pm_o       = 1'b1;
        end
        (bin > 7'd12 && pm_h < 7'd10): begin
          disp_msd_o = 4'd0;
          disp_lsd_o = 4'(pm_h);
          pm_o       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/maq_cont.sv
// Two-digit BCD up/down modulo counter with
// preset, wrap pulses and 12-hour display.
module maq_cont
  import maq_pkg::*;
#(
  parameter int MODULO = 24,
  parameter int MSD_W  = 2,
  parameter int HORA12 = 0
) (
  input  logic             maqc_clock,
  input  logic             maqc_reset,
  input  logic             maqc_enable,
  input  logic             maqc_incremento,
  input  logic             maqc_decremento,
  input  logic             maqc_load,
  input  logic [3:0]       maqc_load_lsd,
  input  logic [MSD_W-1:0] maqc_load_msd,
  input  logic             maqc_modo12,
  output logic [3:0]       maqc_lsd,
  output logic [MSD_W-1:0] maqc_msd,
  output logic             maqc_carry,
  output logic             maqc_borrow,
  output logic             maqc_load_err,
  output logic [3:0]       maqc_disp_lsd,
  output logic [MSD_W-1:0] maqc_disp_msd,
  output logic             maqc_pm
);

  localparam int TOP = MODULO - 1;
  localparam logic [MSD_W-1:0] MAX_MSD =
    MSD_W'(TOP / 10);
  localparam bcd_t MAX_LSD = 4'(TOP % 10);
  localparam logic [6:0] MOD7 = 7'(MODULO);

  if (MODULO < 2 || MODULO > 99) begin : g_bad_mod
    $error("maq_cont: MODULO out of 2..99");
  end
  if ((TOP / 10) >= (1 << MSD_W)) begin : g_bad_w
    $error("maq_cont: MSD_W too narrow");
  end
  if (HORA12 != 0 &&
      (HORA12 != 1 || MODULO != 24)) begin : g_bad_h
    $error("maq_cont: HORA12 needs MODULO=24");
  end

  bcd_t             lsd_q, lsd_d;
  logic [MSD_W-1:0] msd_q, msd_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             err_q, err_d;

  logic ld_ok, step_ok, at_max, at_zero;

  assign ld_ok =
    (maqc_load_lsd <= BCD_MAX) &&
    (int'(maqc_load_msd) <= 9) &&
    (bcd2bin(4'(maqc_load_msd), maqc_load_lsd)
      < MOD7);
  assign step_ok = maqc_enable &&
    (maqc_incremento ^ maqc_decremento);
  assign at_max  = (msd_q == MAX_MSD) &&
                   (lsd_q == MAX_LSD);
  assign at_zero = (msd_q == '0) &&
                   (lsd_q == 4'd0);

  // Next count: load beats step beats hold
  always_comb begin
    lsd_d    = lsd_q;
    msd_d    = msd_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (maqc_load) begin
      if (ld_ok) begin
        lsd_d = maqc_load_lsd;
        msd_d = maqc_load_msd;
      end else begin
        err_d = 1'b1;
      end
    end else if (step_ok && maqc_incremento) begin
      if (at_max) begin
        lsd_d   = 4'd0;
        msd_d   = '0;
        carry_d = 1'b1;
      end else if (lsd_q == BCD_MAX) begin
        lsd_d = 4'd0;
        msd_d = msd_q + 1'b1;
      end else begin
        lsd_d = lsd_q + 4'd1;
      end
    end else if (step_ok) begin
      if (at_zero) begin
        lsd_d    = MAX_LSD;
        msd_d    = MAX_MSD;
        borrow_d = 1'b1;
      end else if (lsd_q == 4'd0) begin
        lsd_d = BCD_MAX;
        msd_d = msd_q - 1'b1;
      end else begin
        lsd_d = lsd_q - 4'd1;
      end
    end
  end

  // Count and event pulse registers
  always_ff @(posedge maqc_clock or
              negedge maqc_reset) begin
    if (!maqc_reset) begin
      lsd_q    <= 4'd0;
      msd_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      lsd_q    <= lsd_d;
      msd_q    <= msd_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign maqc_lsd      = lsd_q;
  assign maqc_msd      = msd_q;
  assign maqc_carry    = carry_q;
  assign maqc_borrow   = borrow_q;
  assign maqc_load_err = err_q;

  if (HORA12 == 1) begin : g_h12
    bcd_t dmsd;
    maq_disp12 u_disp12 (
      .msd_i      (4'(msd_q)),
      .lsd_i      (lsd_q),
      .modo12_i   (maqc_modo12),
      .disp_msd_o (dmsd),
      .disp_lsd_o (maqc_disp_lsd),
      .pm_o       (maqc_pm)
    );
    assign maqc_disp_msd = MSD_W'(dmsd);
  end else begin : g_h24
    logic unused_modo12;
    assign unused_modo12 = maqc_modo12;
    assign maqc_disp_msd = msd_q;
    assign maqc_disp_lsd = lsd_q;
    assign maqc_pm       = 1'b0;
  end

endmodule
